// File: rtl/prbs_checker_pkg.sv
// Shared LFSR definitions for the 4-bit PRBS generator and its checker.
// The polynomial and tap positions live here so both ends agree on them.
package prbs_checker_pkg;

    // Width of the LFSR and of the checker's history window
    localparam int LFSR_W = 4;

    // Tap positions of the recurrence b[n+4] = b[n] ^ b[n+1]
    localparam int TAP_A = 0;
    localparam int TAP_B = 1;

    // Number of acquired bits needed before the history window is trusted (0-based)
    localparam logic [1:0] ACQ_MAX = 2'd3;

    // Checker FSM states
    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_LOCKED  = 1'b1
    } state_e;

    // Feedback bit: next bit of the sequence predicted from the two oldest bits
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] hist);
        return hist[TAP_A] ^ hist[TAP_B];
    endfunction

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear first, otherwise increment until all-ones and hold there
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 4-bit LFSR serial stream.
// Acquires four bits into a history window, then flywheels on its own
// prediction, flagging and counting every received bit that disagrees.
// LOSS_ERRS consecutive disagreements drop it back to acquisition.
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int LOSS_ERRS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sin,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err,
    output logic [CNT_W-1:0]  err_count,
    output logic [LFSR_W-1:0] status
);

    localparam logic [2:0] LOSS_LIMIT = 3'(LOSS_ERRS);
    localparam logic [2:0] MISS_ONE   = 3'd1;
    localparam logic [1:0] ACQ_ONE    = 2'd1;

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] hist_q, hist_d;
    logic [1:0]        acq_cnt_q, acq_cnt_d;
    logic [2:0]        miss_cnt_q, miss_cnt_d;
    logic              err_q, err_d;
    logic              locked_q, locked_d;

    logic              expBit;
    logic              bitIn;
    logic [LFSR_W-1:0] shiftedHist;
    logic              acqDone;
    logic              mismatch;
    logic [2:0]        missInc;
    logic              lossHit;

    // Shared decode: prediction, shifted window and the lock/loss conditions
    always_comb begin
        expBit      = lfsr_fb(hist_q);
        bitIn       = (state_q == ST_LOCKED) ? expBit : sin;
        shiftedHist = {bitIn, hist_q[LFSR_W-1:1]};
        acqDone     = en && (state_q == ST_ACQUIRE) && (acq_cnt_q == ACQ_MAX)
                      && (shiftedHist != '0);
        mismatch    = en && (state_q == ST_LOCKED) && (sin != expBit);
        missInc     = miss_cnt_q + MISS_ONE;
        lossHit     = mismatch && (missInc == LOSS_LIMIT);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACQUIRE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: lock after a full non-zero window, unlock on the final miss
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACQUIRE: if (acqDone) state_d = ST_LOCKED;
            ST_LOCKED:  if (lossHit) state_d = ST_ACQUIRE;
            default:    state_d = ST_ACQUIRE;
        endcase
    end

    // FSM outputs: lock flag follows the next state, err flags this cycle's miss
    always_comb begin
        locked_d = (state_d == ST_LOCKED);
        err_d    = mismatch;
    end

    // History, acquisition and miss counters; frozen on cycles without en
    always_comb begin
        hist_d     = hist_q;
        acq_cnt_d  = acq_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (en) begin
            case (state_q)
                ST_ACQUIRE: begin
                    hist_d    = shiftedHist;
                    acq_cnt_d = (acq_cnt_q == ACQ_MAX) ? ACQ_MAX : acq_cnt_q + ACQ_ONE;
                    if (acqDone) begin
                        miss_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (lossHit) begin
                        hist_d     = '0;
                        acq_cnt_d  = '0;
                        miss_cnt_d = '0;
                    end else if (mismatch) begin
                        hist_d     = shiftedHist;
                        miss_cnt_d = missInc;
                    end else begin
                        hist_d     = shiftedHist;
                        miss_cnt_d = '0;
                    end
                end
                default: begin
                    hist_d = '0;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q     <= '0;
            acq_cnt_q  <= '0;
            miss_cnt_q <= '0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            hist_q     <= hist_d;
            acq_cnt_q  <= acq_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (mismatch),
        .clr_i   (clr_cnt),
        .count_o (err_count)
    );

    assign locked = locked_q;
    assign err    = err_q;
    assign status = hist_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: directed vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_prbs_checker;

    localparam int LOSS = 3;
    localparam int MAX8 = 255;
    localparam int MAX2 = 3;

    logic       clk = 1'b0;
    logic       reset, en, sin, clr_cnt;
    logic       locked, err;
    logic [7:0] errCount;
    logic [3:0] status;
    logic       locked2, err2;
    logic [1:0] errCount2;
    logic [3:0] status2;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit mLocked, mErr;
    int mAcq, mMiss, mCount, mCount2;
    bit win[$];
    bit gen[$];

    typedef struct {
        logic       rst, en, sin, clr;
        logic       expLocked, expErr;
        logic [7:0] expCount;
        logic [3:0] expStatus;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    prbs_checker #(.CNT_W(8), .LOSS_ERRS(LOSS)) dut (
        .clk(clk), .reset(reset), .en(en), .sin(sin), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .err_count(errCount), .status(status)
    );

    prbs_checker #(.CNT_W(2), .LOSS_ERRS(LOSS)) dut2 (
        .clk(clk), .reset(reset), .en(en), .sin(sin), .clr_cnt(clr_cnt),
        .locked(locked2), .err(err2), .err_count(errCount2), .status(status2)
    );

    function automatic void genSeed(input logic [3:0] s);
        gen.delete();
        for (int i = 0; i < 4; i++) gen.push_back(s[i]);
    endfunction

    function automatic bit genNext();
        bit b;
        b = gen[0];
        gen.push_back(gen[0] ^ gen[1]);
        void'(gen.pop_front());
        return b;
    endfunction

    function automatic logic [3:0] winValue();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = win[i];
        return v;
    endfunction

    function automatic void clearWin();
        win.delete();
        repeat (4) win.push_back(1'b0);
    endfunction

    function automatic void modelStep(input bit r, input bit e, input bit s, input bit c);
        bit miss, pred;
        miss = 1'b0;
        if (r) begin
            mLocked = 0; mErr = 0; mAcq = 0; mMiss = 0; mCount = 0; mCount2 = 0;
            clearWin();
            return;
        end
        mErr = 1'b0;
        if (e) begin
            if (!mLocked) begin
                win.push_back(s);
                void'(win.pop_front());
                mAcq++;
                if (mAcq >= 4 && winValue() != 4'b0000) begin
                    mLocked = 1'b1;
                    mMiss   = 0;
                end
            end else begin
                pred = win[0] ^ win[1];
                if (s != pred) begin
                    miss = 1'b1;
                    mErr = 1'b1;
                    mMiss++;
                end else begin
                    mMiss = 0;
                end
                if (mMiss == LOSS) begin
                    mLocked = 1'b0;
                    mAcq    = 0;
                    mMiss   = 0;
                    clearWin();
                end else begin
                    win.push_back(pred);
                    void'(win.pop_front());
                end
            end
        end
        if (c) begin
            mCount  = 0;
            mCount2 = 0;
        end else if (miss) begin
            if (mCount < MAX8) mCount++;
            if (mCount2 < MAX2) mCount2++;
        end
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic s, input logic c);
        reset   = r;
        en      = e;
        sin     = s;
        clr_cnt = c;
        @(posedge clk);
        modelStep(r, e, s, c);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, " locked"},    32'(locked),    32'(mLocked));
        cmp({tag, " err"},       32'(err),       32'(mErr));
        cmp({tag, " count"},     32'(errCount),  32'(mCount));
        cmp({tag, " status"},    32'(status),    32'(winValue()));
        cmp({tag, " locked2"},   32'(locked2),   32'(mLocked));
        cmp({tag, " err2"},      32'(err2),      32'(mErr));
        cmp({tag, " count2"},    32'(errCount2), 32'(mCount2));
        cmp({tag, " status2"},   32'(status2),   32'(winValue()));
    endtask

    task automatic lockClean(input logic [3:0] seed, input int n, input string tag);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, " reset"});
        genSeed(seed);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, genNext(), 1'b0);
            checkOutput(tag);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; sin = 1'b0; clr_cnt = 1'b0;
        clearWin();

        // rst en sin clr | locked err count status  (seed 1000 stream 0,0,0,1,0,0,1,1,0,1,0)
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0000};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0000};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0000};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 4'b1000};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'b0100};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'b0010};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 4'b1001};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 4'b1100};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 4'b0110};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 4'b1011};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 4'b1011};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 4'b0101};

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].sin, vecs[i].clr);
            cmp($sformatf("vec%0d locked", i), 32'(locked),    32'(vecs[i].expLocked));
            cmp($sformatf("vec%0d err", i),    32'(err),       32'(vecs[i].expErr));
            cmp($sformatf("vec%0d count", i),  32'(errCount),  32'(vecs[i].expCount));
            cmp($sformatf("vec%0d status", i), 32'(status),    32'(vecs[i].expStatus));
            cmp($sformatf("vec%0d count2", i), 32'(errCount2), 32'(vecs[i].expCount));
        end

        // Clean stream from seed 1000: lock on the 4th edge, then no errors
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t1 reset");
        genSeed(4'b1000);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 1'b1, genNext(), 1'b0);
            checkOutput("t1");
            if (i == 3) begin
                cmp("t1 lock4", 32'(locked), 32'd1);
                cmp("t1 status4", 32'(status), 32'b1000);
            end
        end
        cmp("t1 noerr", 32'(errCount), 32'd0);

        // All-zero input never locks
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("t2");
        end
        cmp("t2 unlocked", 32'(locked), 32'd0);

        // Single inverted bit while locked
        lockClean(4'b0110, 10, "t3");
        applyStimulus(1'b0, 1'b1, ~genNext(), 1'b0);
        checkOutput("t3 hit");
        cmp("t3 errpulse", 32'(err), 32'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, genNext(), 1'b0);
            checkOutput("t3 after");
        end
        cmp("t3 count", 32'(errCount), 32'd1);
        cmp("t3 stilllocked", 32'(locked), 32'd1);

        // Three consecutive inversions drop lock, then relock after 4 valid bits
        lockClean(4'b1101, 8, "t4");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, ~genNext(), 1'b0);
            checkOutput("t4 hit");
        end
        cmp("t4 lost", 32'(locked), 32'd0);
        cmp("t4 count", 32'(errCount), 32'd3);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, genNext(), 1'b0);
            checkOutput("t4 relock");
            if (i == 2) cmp("t4 notyet", 32'(locked), 32'd0);
            if (i == 3) cmp("t4 relocked", 32'(locked), 32'd1);
        end

        // en toggling: state frozen on idle cycles
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        genSeed(4'b0011);
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) applyStimulus(1'b0, 1'b1, genNext(), 1'b0);
            else            applyStimulus(1'b0, 1'b0, logic'($urandom_range(0, 1)), 1'b0);
            checkOutput("t5");
            if (i == 6) cmp("t5 lock", 32'(locked), 32'd1);
        end

        // Five isolated errors: 2-bit counter saturates at 3
        lockClean(4'b1001, 8, "t6");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, ~genNext(), 1'b0);
            checkOutput("t6 hit");
            for (int i = 0; i < 3; i++) begin
                applyStimulus(1'b0, 1'b1, genNext(), 1'b0);
                checkOutput("t6 gap");
            end
        end
        cmp("t6 count8", 32'(errCount), 32'd5);
        cmp("t6 sat2", 32'(errCount2), 32'd3);

        // Reset while locked overrides other inputs
        applyStimulus(1'b1, 1'b1, ~genNext(), 1'b0);
        checkOutput("t6 reset");
        cmp("t6 rstlock", 32'(locked), 32'd0);
        cmp("t6 rstcnt", 32'(errCount), 32'd0);

        // Randomized run against the model
        genSeed(4'(($urandom_range(1, 15))));
        for (int i = 0; i < 1500; i++) begin
            logic r, e, s, c;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 49) == 0);
            if (e) s = genNext() ^ ($urandom_range(0, 19) == 0);
            else   s = logic'($urandom_range(0, 1));
            applyStimulus(r, e, s, c);
            checkOutput("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
